// File: rtl/return_address_stack.sv
// return_address_stack: call/return LIFO driving the instruction counter write port
module return_address_stack #(
    parameter int DEPTH = 8
) (
    input  logic       RS_clk,
    input  logic       RS_rst,
    input  logic       RS_call,
    input  logic       RS_ret,
    input  logic [7:0] RS_target,
    input  logic [7:0] RS_pc_in,
    input  logic       RS_err_clr,
    output logic [7:0] RS_pc_out,
    output logic       RS_pc_wr_en,
    output logic       RS_busy,
    output logic       RS_full,
    output logic       RS_empty,
    output logic [4:0] RS_depth,
    output logic       RS_overflow,
    output logic       RS_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    logic [0:0]    state;
    logic [7:0]    stack [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          idle;
    logic          do_call;
    logic          do_ret;
    logic          ovf_ev;
    logic          unf_ev;

    assign idle        = state == IDLE;
    assign do_call     = idle & RS_call & ~RS_full;
    assign do_ret      = idle & RS_ret & ~RS_call & ~RS_empty;
    assign ovf_ev      = idle & RS_call & RS_full;
    assign unf_ev      = idle & RS_ret & ~RS_call & RS_empty;
    assign wr_idx      = RS_depth[AW-1:0];
    assign rd_idx      = AW'(RS_depth - 5'd1);
    assign RS_pc_wr_en = state == LOAD;
    assign RS_busy     = state == LOAD;
    assign RS_full     = RS_depth == 5'(DEPTH);
    assign RS_empty    = RS_depth == 5'd0;

    // control state, load address, stack depth and sticky errors (error set beats clear)
    always_ff @(posedge RS_clk or negedge RS_rst) begin
        if (!RS_rst) begin
            state        <= IDLE;
            RS_pc_out    <= 8'h00;
            RS_depth     <= 5'd0;
            RS_overflow  <= 1'b0;
            RS_underflow <= 1'b0;
        end else begin
            state        <= (do_call | do_ret) ? LOAD : IDLE;
            RS_pc_out    <= do_call ? RS_target : do_ret ? stack[rd_idx] : RS_pc_out;
            RS_depth     <= do_call ? RS_depth + 5'd1 : do_ret ? RS_depth - 5'd1 : RS_depth;
            RS_overflow  <= ovf_ev | (RS_overflow & ~RS_err_clr);
            RS_underflow <= unf_ev | (RS_underflow & ~RS_err_clr);
        end
    end

    // stack storage; entries at or above the depth are don't-care so no reset is needed
    always_ff @(posedge RS_clk) begin
        if (do_call) stack[wr_idx] <= 8'(RS_pc_in + 8'd1);
    end
endmodule

// File: doc/return_address_stack.md
# return_address_stack

Call/return controller that drives the write port of the 8-bit instruction counter. On a call it pushes the return address (current counter value + 1) onto an internal LIFO and loads the call target into the counter. On a return it pops the LIFO and loads the popped address into the counter. It sits between the control decoder, which issues call/return requests, and the instruction counter: RS_pc_out feeds the counter's data-in, RS_pc_wr_en feeds its write enable, and RS_pc_in is fed from the counter's output.

## Interface
- DEPTH, 8: number of stack entries; power of two, 2..16.
- RS_clk  in  1  clock; all state changes on the rising edge.
- RS_rst  in  1  reset, asynchronous, active-low.
- RS_call  in  1  call request; sampled only when RS_busy=0.
- RS_ret  in  1  return request; sampled only when RS_busy=0.
- RS_target  in  8  call target address; sampled with RS_call.
- RS_pc_in  in  8  current instruction counter value.
- RS_err_clr  in  1  synchronous clear of the sticky error flags.
- RS_pc_out  out  8  address to load into the instruction counter.
- RS_pc_wr_en  out  1  one-cycle write strobe to the instruction counter.
- RS_busy  out  1  high while a load is in progress; requests are ignored.
- RS_full  out  1  depth == DEPTH.
- RS_empty  out  1  depth == 0.
- RS_depth  out  5  current number of stack entries, 0..DEPTH.
- RS_overflow  out  1  sticky: a call was attempted while full.
- RS_underflow  out  1  sticky: a return was attempted while empty.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - LOAD: RS_pc_wr_en=1, RS_busy=1; always lasts exactly one cycle, then returns to IDLE.
- Request handling in IDLE:
  - RS_call=1 and not full: push (RS_pc_in + 1) mod 256 onto the stack, depth+1, RS_pc_out <= RS_target, go to LOAD.
  - RS_call=1 and full: no push, no load, RS_overflow <= 1, stay in IDLE.
  - RS_ret=1 (RS_call=0) and not empty: pop the top entry into RS_pc_out, depth-1, go to LOAD.
  - RS_ret=1 and empty: no load, RS_underflow <= 1, stay in IDLE.
  - RS_call=1 and RS_ret=1 together: the call has priority and the return is discarded silently.
- Requests presented while in LOAD are ignored; nothing is queued.
- Return-address arithmetic is 8-bit with wrap-around: RS_pc_in=8'hFF pushes 8'h00.
- Stack organisation:
  - Register array with a pointer; the top entry sits at index depth-1.
  - Entries at or above the depth are never read; their contents are don't-care.
- RS_pc_out holds its last loaded value outside LOAD.
- Errors:
  - RS_err_clr=1 clears both flags on the next edge.
  - If a new error event and RS_err_clr occur in the same cycle, the set wins.
  - Error flags do not block later valid requests.
- Reset values:
  - state IDLE, RS_pc_out=8'h00, RS_pc_wr_en=0, RS_busy=0.
  - RS_depth=0, RS_empty=1, RS_full=0, RS_overflow=0, RS_underflow=0.

## Timing
- Request sampled at edge N.
- Between edges N and N+1: RS_pc_wr_en=1, RS_busy=1, RS_pc_out valid. The counter captures the value at edge N+1.
- After edge N+1: IDLE, and a new request can be sampled at edge N+2. Maximum throughput is one call/return per 2 cycles.
- RS_depth, RS_full and RS_empty update at edge N, together with the push or pop.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset asserted at any time, including during LOAD:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - The in-flight load is aborted and the stack is emptied.
- Reset deassertion is synchronised by the integrator; the first request can be sampled on the first edge after release.

## Test plan
- Reset then single call: RS_pc_in=8'h10, RS_target=8'h40, RS_call pulse. Expect one cycle later RS_pc_wr_en=1, RS_pc_out=8'h40, RS_depth=1, RS_empty=0. Then RS_ret pulse: RS_pc_wr_en=1, RS_pc_out=8'h11, RS_depth=0, RS_empty=1.
- Nested calls: push from pc 8'h01..8'h08 with DEPTH=8. Expect RS_full=1 after the 8th. Then 8 returns: RS_pc_out=8'h09, 8'h08, …, 8'h02 in LIFO order.
- Overflow/underflow: a 9th call while full gives no RS_pc_wr_en, RS_overflow=1, depth stays 8. Returning on empty gives no write and RS_underflow=1. RS_err_clr clears both, and the set wins when it coincides with a new error.
- Wrap and conflict:
  - Call with RS_pc_in=8'hFF, then return: expect RS_pc_out=8'h00.
  - RS_call and RS_ret together on depth 1: call taken, depth becomes 2.
- Busy and reset:
  - A request asserted in the LOAD cycle is ignored, and RS_depth is unchanged by it.
  - RS_rst driven low mid-LOAD (not on a clock edge): RS_pc_wr_en drops to 0 immediately, all outputs reset, RS_depth=0.
